rr_req_arbiter: RTL
===================

// Module: rr_req_arbiter
// PURPOSE
//   Round-robin arbiter that shares one downstream resource (one of the lab FSM
//   blocks) among N requesters. Grants exactly one requester at a time. Limits
//   each grant to MAX_HOLD cycles so that no requester can starve the others.
//   Sits between the stimulus sources and the shared FSM; grant drives that
//   FSM's input mux select.
// PARAMETERS
//   N         3   number of requesters (2..8)
//   MAX_HOLD  8   max consecutive cycles one grant may persist (>=2)
//   CW        4   hold counter width; must satisfy 2**CW > MAX_HOLD
//   IW        2   grant index width; must satisfy 2**IW >= N
// PORTS
//   clck      in   1    clock, rising-edge
//   rst       in   1    reset, asynchronous, active-low (0 = reset)
//   req       in   N    request vector; req[i]=1 requests the resource
//   grant     out  N    one-hot grant, registered; all-zero when idle
//   grant_id  out  IW   index of current grantee; valid only while busy=1
//   busy      out  1    1 while any grant is active (== |grant)
//   preempt   out  1    1-cycle pulse: grant removed by MAX_HOLD timeout
// BEHAVIOUR
//   Reset (rst=0, async, takes effect immediately, also mid-grant):
//     - grant=0, grant_id=0, busy=0, preempt=0.
//     - ptr=0 (requester 0 has top priority), hold_cnt=0, state=IDLE.
//   Selection function sel(ptr, mask):
//     - first i with req[i]&mask[i], scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   States:
//     - IDLE: no grant.
//     - GRANT: grant[g]=1.
//   IDLE, any req=1:
//     - next edge: state=GRANT, g=sel(ptr, all ones), hold_cnt=0.
//     - latency req->grant = 1 cycle.
//   IDLE, req=0: stay IDLE.
//   GRANT, each edge, with hold_cnt counting cycles granted minus 1:
//     - a) req[g]=0 (release):
//         - ptr=(g+1) mod N.
//         - if another req pending: grant sel(ptr, ~onehot(g)) on the same edge
//           (back-to-back, no idle cycle), hold_cnt=0.
//         - else: go to IDLE.
//     - b) req[g]=1 and hold_cnt==MAX_HOLD-1 (timeout):
//         - ptr=(g+1) mod N.
//         - if another req pending: grant it, hold_cnt=0, preempt=1 for one cycle.
//         - if g is the sole requester: keep g, hold_cnt=0, preempt=0.
//     - c) otherwise: keep g, hold_cnt+1.
//   Outputs:
//     - grant/grant_id/busy change only on clck edges or on async reset.
//     - grant is never multi-hot; grant_id==log2(grant) when busy=1.
//   Simultaneous events:
//     - If release and timeout coincide, treat as release (preempt=0).
//     - Requests arriving during GRANT are sampled only at arbitration edges.
//   Wrap-around: ptr wraps N-1 -> 0. hold_cnt never exceeds MAX_HOLD-1.
//   Glitch rule: a req dropped and reasserted between edges is not seen.
// TESTING
//   1. rst=0 with req=3'b111 -> grant=0, busy=0, preempt=0 held throughout.
//   2. rst=1, req=3'b010 at cycle 0 -> grant=3'b010, grant_id=1 at edge 1.
//   3. req=3'b111 held, MAX_HOLD=8 -> grants rotate 001,010,100,001,...
//      - each grant lasts 8 cycles; preempt pulses at each rotation.
//   4. Only req[2]=1 for 20 cycles -> grant=3'b100 continuous, preempt never 1.
//   5. Grantee 0 drops req while req=3'b110 -> grant=3'b010 on the next edge
//      with no idle cycle; then req[1] drops -> grant=3'b100.
//   6. Async rst=0 mid-cycle during grant=3'b100 -> grant=0 immediately.
//      - after release with req=3'b111: first grant=3'b001 (ptr reset to 0).

Source files
------------

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter granting one of N requesters at a time, with a
// MAX_HOLD-cycle limit per grant. The grant is registered and one-hot.
module rr_req_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4,
  parameter int IW       = 2
) (
  input  logic          clck,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic          preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        r_state, w_state_n;
  logic [IW-1:0] r_gid, w_gid_n;
  logic [IW-1:0] r_ptr, w_ptr_n;
  logic [CW-1:0] r_hold, w_hold_n;
  logic [N-1:0]  r_grant;
  logic          r_preempt, w_preempt_n;

  logic [N-1:0]  w_gmask;
  logic [N-1:0]  w_others;
  logic [IW-1:0] w_ptr_inc;

  // First requester at or after ptr (circularly) that is also set in mask.
  function automatic logic [IW-1:0] f_sel(input logic [IW-1:0] ptr,
                                          input logic [N-1:0]  mask,
                                          input logic [N-1:0]  rq);
    logic        found;
    int unsigned idx;
    f_sel = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && rq[idx] && mask[idx]) begin
        f_sel = IW'(idx);
        found = 1'b1;
      end
    end
  endfunction

  assign w_gmask   = N'(1) << r_gid;
  assign w_others  = req & ~w_gmask;
  assign w_ptr_inc = (r_gid == IW'(N - 1)) ? '0 : r_gid + 1'b1;

  always_comb begin
    w_state_n   = r_state;
    w_gid_n     = r_gid;
    w_ptr_n     = r_ptr;
    w_hold_n    = r_hold;
    w_preempt_n = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_n = GRANT;
          w_gid_n   = f_sel(r_ptr, '1, req);
          w_hold_n  = '0;
        end
      end
      GRANT: begin
        // Release takes precedence over timeout, so it never raises preempt.
        if (!req[r_gid]) begin
          w_ptr_n  = w_ptr_inc;
          w_hold_n = '0;
          if (|w_others) begin
            w_gid_n = f_sel(w_ptr_inc, ~w_gmask, req);
          end else begin
            w_state_n = IDLE;
          end
        end else if (r_hold == CW'(MAX_HOLD - 1)) begin
          w_ptr_n  = w_ptr_inc;
          w_hold_n = '0;
          if (|w_others) begin
            w_gid_n     = f_sel(w_ptr_inc, ~w_gmask, req);
            w_preempt_n = 1'b1;
          end
        end else begin
          w_hold_n = r_hold + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_gid     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_grant   <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_gid     <= w_gid_n;
      r_ptr     <= w_ptr_n;
      r_hold    <= w_hold_n;
      r_grant   <= (w_state_n == GRANT) ? (N'(1) << w_gid_n) : '0;
      r_preempt <= w_preempt_n;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_gid;
  assign busy     = |r_grant;
  assign preempt  = r_preempt;

endmodule
